periodic_sampler: RTL and testbench
===================================

Name: periodic_sampler

Overview:
- Parametrised periodic sampler: a programmable divider produces a capture tick every cfg_div+1 enabled cycles.
- On each tick the block captures a WIDTH-bit input vector, computes a mode-selectable priority index, and presents both on a valid/ready output port.
- Generalises the fixed divide-by-4 gated-clock sample-and-find-first1 pattern: programmable period, four search modes, backpressure with drop accounting.
- Sits between status/event sources and a consumer (trace, interrupt, perf logic).

Parameters:
- WIDTH, 16, sample vector width; must be >= 2.
- DIV_W, 8, divider counter/config width.
- USE_CG, 1, 1 = capture regs clocked via existing cg cell with capture enable; 0 = plain enable flops on ck. The two settings must be functionally identical.

Ports:
- ck  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  divider run enable
- cfg_div  in  DIV_W  period minus 1
- cfg_mode  in  2  00 first1 from LSB, 01 first0 from LSB, 10 first1 from MSB, 11 first0 from MSB
- din  in  WIDTH  vector to sample
- tick  out  1  capture tick, combinational from div_cnt/en, one-cycle pulse
- out_vld  out  1  sample available
- out_rdy  in  1  consumer accepts
- out_data  out  WIDTH  captured vector
- out_idx  out  $clog2(WIDTH)  bit index of match
- out_hit  out  1  a matching bit existed

Behaviour:
- Reset (async assert, sync-safe deassert handled upstream): div_cnt=0, out_vld=0, out_data=0, out_idx=0, out_hit=0. Assertion mid-operation clears immediately; any pending sample is lost.
- Divider:
  - tick = en && (div_cnt >= cfg_div).
  - When tick, div_cnt <= 0; else if en, div_cnt <= div_cnt+1; else hold.
  - cfg_div=0 gives a tick every enabled cycle.
  - Lowering cfg_div below the current div_cnt ticks on the next enabled cycle, with no 2^DIV_W wrap.
  - en=0 freezes div_cnt and forces tick=0.
- Capture condition: cap = tick && (!out_vld || out_rdy).
- On cap:
  - out_data <= din.
  - out_idx/out_hit <= search(din, cfg_mode). din and cfg_mode are sampled in the same cycle.
  - out_vld <= 1.
- Latency: din at tick cycle T appears with out_vld=1 at T+1.
- Handshake:
  - A transfer occurs when out_vld && out_rdy.
  - If a transfer occurs without cap, out_vld <= 0.
  - A transfer and cap in the same cycle keeps out_vld=1 with new data (back-to-back, no bubble).
  - out_data/out_idx/out_hit are stable while out_vld && !out_rdy.
- Drop: tick && out_vld && !out_rdy discards the new sample; held output is unchanged.
- Search:
  - Modes 00/01 return the lowest matching index; modes 10/11 return the highest.
  - No match: out_hit=0, out_idx=0.
  - Search uses the genlib find-first functions; first0 is first1 of ~din; MSB-side search uses a bit-reversed vector with index = WIDTH-1-i.
- USE_CG=1: the cg enable is cap, driven directly from flops and ports; the capture regs clock on the gated clock. out_vld stays on ck.

Optional Feature:
- Macro: PERIODIC_SAMPLER_DROP_CNT_EN.
- Defined:
  - Adds output drop_cnt (16 bits) and input drop_clr (1 bit).
  - drop_cnt increments on each drop and saturates at 0xFFFF.
  - drop_clr zeroes it; if a drop occurs in the same cycle as drop_clr, the result is 1.
  - Reset value 0.
- Undefined: ports and counter absent; drops are silent.

Decomposition:
- Package periodic_sampler_pkg holds:
  - mode_e enum (FIRST1_LSB, FIRST0_LSB, FIRST1_MSB, FIRST0_MSB).
  - DROP_CNT_W=16.
  - Function for the bit-reverse plus search.
- Sub-module tick_gen (parameter DIV_W; ports ck, rst_n, en, cfg_div, tick). It is reusable for other periodic agents.
- Capture/handshake logic stays in the top module.

Test Plan:
- Reset/idle: rst_n=0 with din=16'hFFFF, en=1 → all outputs 0 and tick=0. Release, cfg_div=3 → first tick at cycle 4 after release, then every 4 cycles.
- Modes: din=16'h0120, out_rdy=1 → mode 00 idx=5 hit=1; mode 10 idx=8; mode 01 idx=0; din=16'hFFFF with mode 01 → hit=0, idx=0.
- Backpressure: cfg_div=0, din increments each cycle, out_rdy=0 for 5 cycles → out_data holds first captured value. Raise out_rdy → next value is the sample at the ready cycle; with the macro, drop_cnt=4.
- Back-to-back: cfg_div=0, out_rdy=1 constant → out_vld continuously 1, out_data equals din delayed one cycle.
- Dynamic config: div_cnt=10 with cfg_div=20, change to 5 → tick next cycle. Then en=0 for 3 cycles → div_cnt frozen, no tick.
- Reset mid-op: assert rst_n low while out_vld=1, out_rdy=0 → out_vld=0 in the same cycle, without waiting for a clock edge; drop_cnt=0. Run all of the above with USE_CG=0 and USE_CG=1 → identical traces.

Source files
------------

// File: rtl/periodic_sampler_pkg.sv
// Shared types and the bit-search helper for periodic_sampler.
package periodic_sampler_pkg;

  localparam int unsigned DROP_CNT_W = 16;

  // Widest sample vector the search helper supports.
  localparam int unsigned MaxW    = 64;
  localparam int unsigned IdxMaxW = 6;

  typedef enum logic [1:0] {
    FIRST1_LSB = 2'b00,
    FIRST0_LSB = 2'b01,
    FIRST1_MSB = 2'b10,
    FIRST0_MSB = 2'b11
  } mode_e;

  typedef struct packed {
    logic                 hit;
    logic [IdxMaxW-1:0]   idx;
  } search_t;

  // first0 is first1 of the inverted vector; MSB-side search walks the bit-reversed
  // vector, so position i of the reversed view maps back to index width-1-i.
  function automatic search_t find_first(input logic [MaxW-1:0] v, input int width,
                                         input mode_e mode);
    search_t            r;
    logic [MaxW-1:0]    m;
    logic               found;
    logic               msb_side;
    logic [IdxMaxW-1:0] b;
    r        = '0;
    found    = 1'b0;
    msb_side = (mode == FIRST1_MSB) || (mode == FIRST0_MSB);
    m        = ((mode == FIRST0_LSB) || (mode == FIRST0_MSB)) ? ~v : v;
    for (int i = 0; i < int'(MaxW); i++) begin
      if (i < width && !found) begin
        b = msb_side ? IdxMaxW'(width - 1 - i) : IdxMaxW'(i);
        if (m[b]) begin
          found = 1'b1;
          r.hit = 1'b1;
          r.idx = b;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Programmable divider: one-cycle tick every cfg_div+1 enabled cycles.
module tick_gen #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             ck,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             tick
);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;

  // Compare with >= so lowering cfg_div below the count ticks at once instead of wrapping.
  always_comb begin
    tick      = en && (div_cnt_q >= cfg_div);
    div_cnt_d = div_cnt_q;
    if (tick) begin
      div_cnt_d = '0;
    end else if (en) begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end
  end

  // Divider counter state.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/periodic_sampler.sv
// Periodic sampler: captures din on each divider tick, reports a mode-selected priority
// index, and offers the result on a valid/ready port. Define PERIODIC_SAMPLER_DROP_CNT_EN
// to add a saturating drop counter (drop_cnt) with clear (drop_clr).
module periodic_sampler
  import periodic_sampler_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIV_W  = 8,
  parameter int unsigned USE_CG = 1
) (
  input  logic                     ck,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [DIV_W-1:0]         cfg_div,
  input  logic [1:0]               cfg_mode,
  input  logic [WIDTH-1:0]         din,
  output logic                     tick,
  output logic                     out_vld,
  input  logic                     out_rdy,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(WIDTH)-1:0] out_idx,
`ifdef PERIODIC_SAMPLER_DROP_CNT_EN
  input  logic                     drop_clr,
  output logic [DROP_CNT_W-1:0]    drop_cnt,
`endif
  output logic                     out_hit
);

  localparam int unsigned IdxW = $clog2(WIDTH);

  logic             cap, xfer, drop;
  logic             out_vld_q, out_vld_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             hit_q, hit_d;
  search_t          srch;
  logic             unused_srch;

  tick_gen #(
    .DIV_W(DIV_W)
  ) u_tick_gen (
    .ck     (ck),
    .rst_n  (rst_n),
    .en     (en),
    .cfg_div(cfg_div),
    .tick   (tick)
  );

  // Capture/handshake decode and capture data path.
  always_comb begin
    cap       = tick && (!out_vld_q || out_rdy);
    xfer      = out_vld_q && out_rdy;
    drop      = tick && out_vld_q && !out_rdy;
    out_vld_d = out_vld_q;
    if (cap) begin
      out_vld_d = 1'b1;
    end else if (xfer) begin
      out_vld_d = 1'b0;
    end
    srch   = find_first(MaxW'(din), int'(WIDTH), mode_e'(cfg_mode));
    data_d = din;
    idx_d  = srch.idx[IdxW-1:0];
    hit_d  = srch.hit;
  end

  // Index bits above IdxW are always zero for legal WIDTH.
  assign unused_srch = ^srch.idx;

  // Valid flag stays on the free-running clock.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q <= 1'b0;
    end else begin
      out_vld_q <= out_vld_d;
    end
  end

  if (USE_CG != 0) begin : g_cg
    logic cg_en_l;
    logic gck;

    // Clock gate: enable latched while ck is low so gck cannot glitch.
    always_latch begin
      if (!ck) begin
        cg_en_l <= cap;
      end
    end
    assign gck = ck & cg_en_l;

    // Capture registers on the gated clock; every gck edge is a capture.
    always_ff @(posedge gck or negedge rst_n) begin
      if (!rst_n) begin
        data_q <= '0;
        idx_q  <= '0;
        hit_q  <= 1'b0;
      end else begin
        data_q <= data_d;
        idx_q  <= idx_d;
        hit_q  <= hit_d;
      end
    end
  end else begin : g_plain
    // Capture registers as enable flops on ck.
    always_ff @(posedge ck or negedge rst_n) begin
      if (!rst_n) begin
        data_q <= '0;
        idx_q  <= '0;
        hit_q  <= 1'b0;
      end else if (cap) begin
        data_q <= data_d;
        idx_q  <= idx_d;
        hit_q  <= hit_d;
      end
    end
  end

`ifdef PERIODIC_SAMPLER_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  // Saturating drop count; a drop coinciding with clear leaves a count of one.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_clr) begin
      drop_cnt_d = drop ? DROP_CNT_W'(1) : '0;
    end else if (drop && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
    end
  end

  // Drop counter state.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

  assign out_vld  = out_vld_q;
  assign out_data = data_q;
  assign out_idx  = idx_q;
  assign out_hit  = hit_q;

endmodule

// File: tb/tb_periodic_sampler.sv
// Bench for periodic_sampler: gated-clock and plain-enable builds side by side, checked
// against a behavioural model plus directed vectors.
module tb_periodic_sampler;

  logic        ck;
  logic        rst_n;
  logic        en;
  logic [7:0]  cfg_div;
  logic [1:0]  cfg_mode;
  logic [15:0] din;
  logic        out_rdy;
  logic        tick0, vld0, hit0, tick1, vld1, hit1;
  logic [15:0] data0, data1;
  logic [3:0]  idx0, idx1;
`ifdef PERIODIC_SAMPLER_DROP_CNT_EN
  logic        drop_clr;
  logic [15:0] drop_cnt0, drop_cnt1;
`endif

  int n_chk;
  int n_fail;

  // Behavioural model state
  int          m_cnt;
  bit          m_vld;
  logic [15:0] m_data;
  int          m_idx;
  bit          m_hit;
  int          m_drop;
  bit          m_tick;
  logic        last_tick;

  typedef struct {
    logic [15:0] din;
    logic [1:0]  mode;
    int          idx;
    bit          hit;
  } vec_t;
  vec_t vecs[10];

  periodic_sampler #(.WIDTH(16), .DIV_W(8), .USE_CG(1)) u_dut0 (
    .ck(ck), .rst_n(rst_n), .en(en), .cfg_div(cfg_div), .cfg_mode(cfg_mode), .din(din),
    .tick(tick0), .out_vld(vld0), .out_rdy(out_rdy), .out_data(data0), .out_idx(idx0),
`ifdef PERIODIC_SAMPLER_DROP_CNT_EN
    .drop_clr(drop_clr), .drop_cnt(drop_cnt0),
`endif
    .out_hit(hit0)
  );

  periodic_sampler #(.WIDTH(16), .DIV_W(8), .USE_CG(0)) u_dut1 (
    .ck(ck), .rst_n(rst_n), .en(en), .cfg_div(cfg_div), .cfg_mode(cfg_mode), .din(din),
    .tick(tick1), .out_vld(vld1), .out_rdy(out_rdy), .out_data(data1), .out_idx(idx1),
`ifdef PERIODIC_SAMPLER_DROP_CNT_EN
    .drop_clr(drop_clr), .drop_cnt(drop_cnt1),
`endif
    .out_hit(hit1)
  );

  initial begin
    ck = 1'b0;
    forever #5 ck = ~ck;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference search: scan every bit, keep the first match (LSB modes) or the last (MSB).
  task automatic ref_search(input logic [15:0] v, input logic [1:0] mode,
                            output bit hit, output int idx);
    logic want;
    want = ~mode[0];
    hit  = 0;
    idx  = 0;
    for (int i = 0; i < 16; i++) begin
      if (v[i] == want && (!hit || mode[1])) begin
        idx = i;
        hit = 1;
      end
    end
  endtask

  task automatic model_reset();
    m_cnt  = 0;
    m_vld  = 0;
    m_data = '0;
    m_idx  = 0;
    m_hit  = 0;
    m_drop = 0;
  endtask

  // One clock with the current inputs: check tick, advance the model, check outputs.
  task automatic cycle();
    bit cap, drop, h;
    int ix;
    #1;
    m_tick    = en && (m_cnt >= int'(cfg_div));
    last_tick = tick0;
    chk("tick", {31'd0, tick0}, {31'd0, m_tick});
    cap  = m_tick && (!m_vld || out_rdy);
    drop = m_tick && m_vld && !out_rdy;
    ref_search(din, cfg_mode, h, ix);
    @(posedge ck);
    #1;
    if (m_tick) m_cnt = 0;
    else if (en) m_cnt = m_cnt + 1;
    if (cap) begin
      m_data = din;
      m_hit  = h;
      m_idx  = ix;
      m_vld  = 1;
    end else if (m_vld && out_rdy) begin
      m_vld = 0;
    end
`ifdef PERIODIC_SAMPLER_DROP_CNT_EN
    if (drop_clr) m_drop = drop ? 1 : 0;
    else if (drop && m_drop < 65535) m_drop = m_drop + 1;
    chk("drop_cnt", {16'd0, drop_cnt0}, m_drop);
    chk("drop_cnt_cg_vs_plain", {16'd0, drop_cnt1}, {16'd0, drop_cnt0});
`else
    if (drop) m_drop = m_drop + 1;
`endif
    chk("out_vld", {31'd0, vld0}, {31'd0, m_vld});
    chk("out_data", {16'd0, data0}, {16'd0, m_data});
    chk("out_idx", {28'd0, idx0}, m_idx);
    chk("out_hit", {31'd0, hit0}, {31'd0, m_hit});
    chk("cg_vs_plain", {9'd0, vld1, data1, idx1, hit1, tick1},
        {9'd0, vld0, data0, idx0, hit0, tick0});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    @(posedge ck);
    #1;
    rst_n = 1'b1;
  endtask

  logic [15:0] prev;

  initial begin
    n_chk = 0;
    n_fail = 0;
    vecs[0] = '{16'h0120, 2'b00, 5, 1};
    vecs[1] = '{16'h0120, 2'b10, 8, 1};
    vecs[2] = '{16'h0120, 2'b01, 0, 1};
    vecs[3] = '{16'hFFFF, 2'b01, 0, 0};
    vecs[4] = '{16'h0120, 2'b11, 15, 1};
    vecs[5] = '{16'h0000, 2'b00, 0, 0};
    vecs[6] = '{16'h8000, 2'b00, 15, 1};
    vecs[7] = '{16'h7FFF, 2'b11, 15, 1};
    vecs[8] = '{16'hFFFE, 2'b01, 0, 1};
    vecs[9] = '{16'h0001, 2'b10, 0, 1};

    rst_n    = 1'b0;
    en       = 1'b1;
    cfg_div  = 8'd3;
    cfg_mode = 2'b00;
    din      = 16'hFFFF;
    out_rdy  = 1'b0;
`ifdef PERIODIC_SAMPLER_DROP_CNT_EN
    drop_clr = 1'b0;
`endif
    model_reset();
    #2;
    chk("rst_vld", {31'd0, vld0}, 32'd0);
    chk("rst_data", {16'd0, data0}, 32'd0);
    chk("rst_idx", {28'd0, idx0}, 32'd0);
    chk("rst_hit", {31'd0, hit0}, 32'd0);
    chk("rst_tick", {31'd0, tick0}, 32'd0);
    chk("rst_plain", {9'd0, vld1, data1, idx1, hit1, tick1}, 32'd0);
    @(posedge ck);
    #1;
    chk("rst_hold_data", {16'd0, data0}, 32'd0);
    rst_n = 1'b1;

    // Tick cadence with cfg_div=3: ticks on the 4th cycle after release, then every 4
    for (int c = 0; c < 12; c++) begin
      cycle();
      chk("tick_cadence", {31'd0, last_tick}, {31'd0, ((c % 4) == 3)});
    end

    // Search modes
    do_reset();
    cfg_div = 8'd0;
    out_rdy = 1'b1;
    for (int v = 0; v < 10; v++) begin
      din      = vecs[v].din;
      cfg_mode = vecs[v].mode;
      cycle();
      chk("mode_idx", {28'd0, idx0}, vecs[v].idx);
      chk("mode_hit", {31'd0, hit0}, {31'd0, vecs[v].hit});
      chk("mode_data", {16'd0, data0}, {16'd0, vecs[v].din});
    end

    // Backpressure: first sample held, four drops, then the ready-cycle sample
    do_reset();
    cfg_div  = 8'd0;
    cfg_mode = 2'b00;
    out_rdy  = 1'b0;
    for (int c = 0; c < 5; c++) begin
      din = 16'h1000 + 16'(c);
      cycle();
      chk("bp_hold", {16'd0, data0}, 32'h1000);
    end
    out_rdy = 1'b1;
    din     = 16'h1005;
    cycle();
    chk("bp_release", {16'd0, data0}, 32'h1005);
`ifdef PERIODIC_SAMPLER_DROP_CNT_EN
    chk("bp_drops", {16'd0, drop_cnt0}, 32'd4);
`endif

    // Back-to-back: no bubble, data is din delayed one cycle
    for (int c = 0; c < 8; c++) begin
      din  = 16'($urandom);
      prev = din;
      cycle();
      chk("b2b_vld", {31'd0, vld0}, 32'd1);
      chk("b2b_data", {16'd0, data0}, {16'd0, prev});
    end

    // Dynamic config: lower cfg_div under the running count, then freeze with en=0
    do_reset();
    cfg_div = 8'd20;
    for (int c = 0; c < 10; c++) cycle();
    cfg_div = 8'd5;
    cycle();
    chk("dyn_tick", {31'd0, last_tick}, 32'd1);
    cycle();
    cycle();
    en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      cycle();
      chk("frozen_tick", {31'd0, last_tick}, 32'd0);
    end
    en = 1'b1;
    for (int c = 0; c < 4; c++) begin
      cycle();
      chk("resume_tick", {31'd0, last_tick}, {31'd0, (c == 3)});
    end

    // Reset mid-operation clears outputs without a clock edge
    cfg_div = 8'd0;
    out_rdy = 1'b0;
    din     = 16'hABCD;
    cycle();
    cycle();
    chk("pre_rst_vld", {31'd0, vld0}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_vld", {30'd0, vld0, vld1}, 32'd0);
    chk("async_rst_data", {data0, data1}, 32'd0);
`ifdef PERIODIC_SAMPLER_DROP_CNT_EN
    chk("async_rst_drop", {drop_cnt0, drop_cnt1}, 32'd0);
`endif
    model_reset();
    @(posedge ck);
    #1;
    rst_n = 1'b1;

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 15) == 0) cfg_div = 8'($urandom_range(0, 6));
      en       = ($urandom_range(0, 7) != 0);
      out_rdy  = $urandom_range(0, 1) == 1;
      din      = 16'($urandom);
      cfg_mode = 2'($urandom_range(0, 3));
`ifdef PERIODIC_SAMPLER_DROP_CNT_EN
      drop_clr = ($urandom_range(0, 15) == 0);
`endif
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
